i2s_sample_tx: RTL and testbench

- Downstream audio output stage of the USB MIDI audio synth.
- Accepts stereo PCM sample pairs from the synth voice mixer through a valid/ready handshake and buffers them in a small FIFO.
- Generates BCLK and LRCLK from the I2S clock supplied by the system.
- Serialises samples MSB-first in Philips I2S format to the codec DAC input. The codec is configured separately over I2C.

---
 rtl/i2s_sample_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_i2s_sample_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx
// Output stage of the synth. Stereo PCM pairs come in through a valid/ready
// handshake, wait in a small FIFO, and are sent to the codec DAC as Philips
// I2S. Each channel goes out MSB-first in a 32-bit slot, padded with zeros.
// BCLK and LRCLK are derived from clk_clk.
//
// Parameters:
//   DATA_W     - sample width per channel (8..32)
//   FIFO_DEPTH - sample-pair FIFO entries (power of two, >= 2)
//   BCLK_DIV   - clk_clk cycles per BCLK period (even, >= 2)
//
// Ports:
//   clk_clk        in   I2S clock; all logic runs on the rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   enable         in   run request; sampled in IDLE and at frame wrap
//   s_left/s_right in   two's complement sample pair
//   s_valid        in   sample pair valid
//   s_ready        out  FIFO can accept a pair
//   i2s_bclk       out  bit clock
//   i2s_lrclk      out  word select (0 = left, 1 = right)
//   i2s_dout       out  serial data
//   fifo_level     out  occupied FIFO entries
//   underflow_cnt  out  frames started with an empty FIFO (saturating)
//
// Build option:
//   I2S_UNDERFLOW_HOLD_EN - when defined, an underflow frame repeats the last
//   popped pair. When undefined, an underflow frame sends all-zero slots.

module i2s_sample_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN} state_t;

  // FIFO storage, one {left, right} pair per entry
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [LVL_W-1:0]    level_next;
  logic                ready_reg;

  state_t              state_reg;
  logic [DIV_W-1:0]    div_reg;
  logic [DIV_W-1:0]    div_next;
  logic [5:0]          bit_cnt_reg;
  logic [5:0]          bit_cnt_next;
  logic [63:0]         shift_reg;
  logic                bclk_reg;
  logic                lrclk_reg;
  logic                dout_reg;
  logic [15:0]         uflow_reg;

  logic                push;
  logic                pop;
  logic                bit_tick;
  logic                frame_wrap;
  logic                frame_start;
  logic [2*DATA_W-1:0] head_pair;
  logic [2*DATA_W-1:0] src_pair;
  logic [31:0]         slot_word [2];
  logic [63:0]         frame_word;

  // The head entry is read combinationally. The shift register captures it
  // at frame start, so a pair written one cycle before a frame start is
  // still sent in that frame.
  assign head_pair = mem[rd_ptr_reg];

`ifdef I2S_UNDERFLOW_HOLD_EN
  logic [2*DATA_W-1:0] last_pair_reg;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_pair_reg <= '0;
    end else if (pop) begin
      last_pair_reg <= head_pair;
    end
  end

  assign src_pair = pop ? head_pair : last_pair_reg;
`else
  assign src_pair = pop ? head_pair : '0;
`endif

  // Left-justify each channel into its 32-bit slot (gi = 1 is left, gi = 0 is right).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_word[gi] = 32'(src_pair[gi*DATA_W +: DATA_W]) << (32 - DATA_W);
    end
  endgenerate

  assign frame_word = {slot_word[1], slot_word[0]};

  always_comb begin
    push         = s_valid && ready_reg;
    bit_tick     = (state_reg == ST_RUN) && (div_reg == DIV_LAST);
    frame_wrap   = bit_tick && (bit_cnt_reg == 6'd63);
    frame_start  = (state_reg == ST_START) || (frame_wrap && enable);
    pop          = frame_start && (level_reg != '0);
    div_next     = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
    bit_cnt_next = bit_cnt_reg + 6'd1;
    level_next   = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  // The memory array is not reset. Resetting the pointers is enough to
  // discard its contents.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      ready_reg   <= 1'b1;
      state_reg   <= ST_IDLE;
      div_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b1;
      dout_reg    <= 1'b0;
      uflow_reg   <= '0;
    end else begin
      level_reg <= level_next;
      // Ready follows the updated level, so the cycle of the last accepted
      // push already blocks a further push.
      ready_reg <= (level_next < LVL_FULL);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (frame_start && !pop && (uflow_reg != 16'hFFFF)) begin
        uflow_reg <= uflow_reg + 16'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          bclk_reg    <= 1'b0;
          lrclk_reg   <= 1'b1;
          dout_reg    <= 1'b0;
          div_reg     <= '0;
          bit_cnt_reg <= '0;
          if (enable) begin
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          bclk_reg    <= 1'b0;
          lrclk_reg   <= 1'b0;
          dout_reg    <= 1'b0;
          div_reg     <= '0;
          bit_cnt_reg <= '0;
          shift_reg   <= frame_word;
          state_reg   <= ST_RUN;
        end
        ST_RUN: begin
          div_reg  <= div_next;
          bclk_reg <= (div_next >= DIV_HALF);
          if (bit_tick) begin
            bit_cnt_reg <= bit_cnt_next;
            if (frame_wrap && !enable) begin
              state_reg <= ST_IDLE;
              lrclk_reg <= 1'b1;
              dout_reg  <= 1'b0;
            end else begin
              // DOUT is one BCLK behind the slot position. Bit k of the frame
              // carries slot bit k-1, and bit 0 carries the last bit of the
              // previous frame.
              lrclk_reg <= bit_cnt_next[5];
              dout_reg  <= shift_reg[63];
              shift_reg <= frame_start ? frame_word : {shift_reg[62:0], 1'b0};
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready       = ready_reg;
  assign i2s_bclk      = bclk_reg;
  assign i2s_lrclk     = lrclk_reg;
  assign i2s_dout      = dout_reg;
  assign fifo_level    = level_reg;
  assign underflow_cnt = uflow_reg;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Testbench for i2s_sample_tx with the default parameters (16-bit samples,
// FIFO of 8, BCLK_DIV of 4). The stimulus pushes each expected frame into a
// queue. A separate monitor deserialises the I2S stream and checks every
// finished frame against the head of that queue.

module tb_i2s_sample_tx;

`ifdef I2S_UNDERFLOW_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dout;
  logic [3:0]  fifo_level;
  logic [15:0] underflow_cnt;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_pair = '0;

  i2s_sample_tx #(.DATA_W(16), .FIFO_DEPTH(8), .BCLK_DIV(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .s_left        (s_left),
    .s_right       (s_right),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_dout      (i2s_dout),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fw(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0000, r, 16'h0000};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    int w;
    @(negedge clk);
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    w = 0;
    while (!s_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
    exp_q.push_back(fw(l, r));
    last_pair = fw(l, r);
  endtask

  // Count consecutive negedges with LRCLK at lvl, starting from 'start'
  // samples already seen.
  task automatic run_len(input logic lvl, input int start, output int n);
    n = start;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (i2s_lrclk !== lvl) break;
      n++;
    end
  endtask

  task automatic wait_level(input int tgt, input string nm);
    for (int k = 0; k < 4000; k++) begin
      if (fifo_level == 4'(tgt)) break;
      @(negedge clk);
    end
    check(nm, 64'(fifo_level), 64'(tgt));
  endtask

  // Monitor: LRCLK falling marks frame start, and DOUT is captured on each
  // BCLK rise. Bit k (k >= 1) of the frame is slot bit k-1.
  initial begin
    logic        active;
    logic        prev_lr;
    logic        prev_bclk;
    logic        bit0;
    logic [63:0] word;
    logic [63:0] e;
    int          idx;
    int          lr_err;
    int          frame_no;
    active = 1'b0;
    prev_lr = 1'b1;
    prev_bclk = 1'b0;
    bit0 = 1'b0;
    word = '0;
    idx = 0;
    lr_err = 0;
    frame_no = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        prev_lr = 1'b1;
        prev_bclk = 1'b0;
      end else begin
        if (prev_lr && !i2s_lrclk) begin
          active = 1'b1;
          idx = 0;
          word = '0;
          lr_err = 0;
        end
        if (active && !prev_bclk && i2s_bclk) begin
          if (i2s_lrclk !== (idx >= 32)) lr_err++;
          if (idx == 0) bit0 = i2s_dout;
          else word[6'(64 - idx)] = i2s_dout;
          idx++;
          if (idx == 64) begin
            active = 1'b0;
            frame_no++;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_unexpected: got %h required none", word);
            end else begin
              e = exp_q.pop_front();
              $display("frame %0d: data=%h expected=%h", frame_no, word, e);
              check("frame_data", word, e);
              check("frame_lrclk_slots", 64'(lr_err), 64'(0));
              check("frame_bit0_pad", 64'(bit0), 64'(0));
            end
          end
        end
        prev_lr = i2s_lrclk;
        prev_bclk = i2s_bclk;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_bclk", 64'(i2s_bclk), 64'(0));
    check("rst_lrclk", 64'(i2s_lrclk), 64'(1));
    check("rst_dout", 64'(i2s_dout), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_uflow", 64'(underflow_cnt), 64'(0));

    // frame format, then mid-frame disable in the second frame
    push_pair(16'h8001, 16'h7FFE);
    push_pair(16'h0F0F, 16'hA5A5);
    check("ff_level2", 64'(fifo_level), 64'(2));
    enable = 1'b1;
    @(negedge clk);
    check("ff_lr_in_start", 64'(i2s_lrclk), 64'(1));
    @(negedge clk);
    check("ff_lr_fall", 64'(i2s_lrclk), 64'(0));
    check("ff_level_pop", 64'(fifo_level), 64'(1));
    repeat (3) @(negedge clk);
    check("ff_dout_bit0", 64'(i2s_dout), 64'(0));
    @(negedge clk);
    check("ff_dout_msb", 64'(i2s_dout), 64'(1));
    run_len(1'b0, 5, n);
    check("ff_lr_low_len", 64'(n), 64'(128));
    run_len(1'b1, 1, n);
    check("ff_lr_high_len", 64'(n), 64'(128));
    repeat (80) @(negedge clk);
    enable = 1'b0;
    run_len(1'b0, 81, n);
    check("md_lr_low_len", 64'(n), 64'(128));
    repeat (127) @(negedge clk);
    check("md_bit63_bclk", 64'(i2s_bclk), 64'(1));
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i2s_lrclk !== 1'b1 || i2s_bclk !== 1'b0) errs++;
    end
    check("md_idle_pins", 64'(errs), 64'(0));
    check("md_no_pop_uflow", 64'(underflow_cnt), 64'(0));
    check("md_sb_drained", 64'(exp_q.size()), 64'(0));

    // backpressure
    for (int i = 1; i <= 8; i++) begin
      push_pair(16'h1100 + 16'(i), 16'h2200 + 16'(i));
      check("bp_ready_after_push", 64'(s_ready), 64'(i < 8));
    end
    check("bp_level_full", 64'(fifo_level), 64'(8));
    @(negedge clk);
    s_left = 16'hC0DE;
    s_right = 16'h0BAD;
    s_valid = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_ready_held", 64'(s_ready), 64'(0));
    check("bp_level_held", 64'(fifo_level), 64'(8));
    enable = 1'b1;
    @(negedge clk);
    check("bp_ready_start", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("bp_ready_rise", 64'(s_ready), 64'(1));
    check("bp_level_pop", 64'(fifo_level), 64'(7));
    @(negedge clk);
    s_valid = 1'b0;
    exp_q.push_back(fw(16'hC0DE, 16'h0BAD));
    last_pair = fw(16'hC0DE, 16'h0BAD);
    check("bp_level_refill", 64'(fifo_level), 64'(8));
    check("bp_ready_refull", 64'(s_ready), 64'(0));

    // drain to level 3, stop, then push on the START cycle
    wait_level(3, "sp_reach_level3");
    enable = 1'b0;
    repeat (300) @(negedge clk);
    check("sp_idle_lrclk", 64'(i2s_lrclk), 64'(1));
    enable = 1'b1;
    @(negedge clk);
    check("sp_ready_start", 64'(s_ready), 64'(1));
    s_left = 16'h1234;
    s_right = 16'h4321;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    exp_q.push_back(fw(16'h1234, 16'h4321));
    last_pair = fw(16'h1234, 16'h4321);
    check("sp_level_same", 64'(fifo_level), 64'(3));
    wait_level(0, "sp_drain");
    enable = 1'b0;
    repeat (300) @(negedge clk);
    check("sp_uflow_none", 64'(underflow_cnt), 64'(0));
    check("sp_sb_drained", 64'(exp_q.size()), 64'(0));

    // underflow: three frames with an empty FIFO
    for (int i = 0; i < 3; i++) exp_q.push_back(HOLD ? last_pair : 64'h0);
    enable = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (underflow_cnt == 16'd3) break;
    end
    enable = 1'b0;
    check("uf_count_reached", 64'(underflow_cnt), 64'(3));
    repeat (300) @(negedge clk);
    check("uf_count_final", 64'(underflow_cnt), 64'(3));
    check("uf_level", 64'(fifo_level), 64'(0));
    check("uf_sb_drained", 64'(exp_q.size()), 64'(0));

    // async reset mid-frame with level 5
    for (int i = 0; i < 6; i++) push_pair(16'hFFFF, 16'hFFFF);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_level5", 64'(fifo_level), 64'(5));
    repeat (40) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (i2s_bclk) break;
      @(negedge clk);
    end
    check("ar_bclk_high_before", 64'(i2s_bclk), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_bclk", 64'(i2s_bclk), 64'(0));
    check("ar_lrclk", 64'(i2s_lrclk), 64'(1));
    check("ar_dout", 64'(i2s_dout), 64'(0));
    check("ar_level", 64'(fifo_level), 64'(0));
    check("ar_ready", 64'(s_ready), 64'(1));
    check("ar_uflow", 64'(underflow_cnt), 64'(0));
    exp_q.delete();
    last_pair = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // one frame after reset: stale FIFO data must not appear
    push_pair(16'h5A5A, 16'h0001);
    check("pr_level1", 64'(fifo_level), 64'(1));
    enable = 1'b1;
    wait_level(0, "pr_pop");
    enable = 1'b0;
    repeat (300) @(negedge clk);
    check("pr_uflow", 64'(underflow_cnt), 64'(0));
    check("pr_sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
